seq_multi_param: RTL
====================

# seq_multi_param

Parametrised sequential shift-add multiplier. Multiplies two WIDTH-bit operands, unsigned or two's-complement signed, over WIDTH+1 clock cycles and returns a 2·WIDTH-bit product. Replaces the free-running fixed 4-bit sequential multiplier with an explicit start/busy/done handshake, so a controller or testbench can issue operations on demand and know when the result is valid.

## Interface
- WIDTH, 4, operand width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; honoured only while busy = 0.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; p is valid from this cycle on.
- p  output  2·WIDTH  product register; holds its value until the next done.

## Operation
- FSM states and transitions:
  - IDLE: on start, go to RUN.
  - RUN: stay for exactly WIDTH cycles, then go to DONE.
  - DONE: go to IDLE unconditionally.
- Capture on start in IDLE:
  - signed_mode is latched as smode.
  - Operand magnitudes are loaded: mcand = |a|, mplier = |b|. In unsigned mode the raw values are used.
  - neg = smode & (a[MSB] ^ b[MSB]).
  - acc (2·WIDTH bits) and the cycle counter (clog2(WIDTH+1) bits) are cleared.
- Each RUN cycle:
  - If mplier[0] = 1, add mcand to acc.
  - Shift mcand left by 1 and mplier right by 1.
  - Increment the counter.
- DONE state:
  - p <= neg ? −acc : acc, as a 2·WIDTH-bit two's complement value.
  - done = 1 for this cycle only.
- Width rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits, so no overflow.
  - Every signed and unsigned product fits exactly in 2·WIDTH bits. No truncation and no saturation.
- a, b and signed_mode are ignored after capture. Changing them mid-operation has no effect.
- start while busy = 1, including the DONE cycle, is ignored and not queued.
- start held high continuously: the next operation is accepted in the first IDLE cycle after DONE.
- A zero operand takes the full WIDTH cycles. There is no early termination.

## Timing
- Reset values while rst_n = 0, effective immediately and without waiting for clk:
  - State is IDLE.
  - busy = 0, done = 0, p = 0.
  - Internal registers are 0.
- Reset asserted mid-operation aborts the operation. p reads 0 and no done is produced.
- busy and done are registered state decodes with no combinational path from inputs.
- Latency:
  - Edge k samples start = 1, and busy rises after edge k.
  - done and the new p appear after edge k+WIDTH+1, and done falls after edge k+WIDTH+2.
- Throughput: one result per WIDTH+2 cycles when start is held high.

## Test plan
- WIDTH=4, unsigned, a=3, b=5, start pulsed once:
  - done goes high exactly 5 cycles after the start edge, with p=8'd15.
  - busy is high for 5 cycles, and p holds 15 afterwards.
- WIDTH=4, unsigned, back-to-back with start held high:
  - 8×9 gives p=8'd72.
  - 12×12 gives p=8'd144.
  - 15×15 gives p=8'd225.
  - Each done is 6 cycles apart.
- WIDTH=4, signed:
  - −3×5 (a=4'hD, b=4'h5) gives p=8'hF1.
  - −8×−8 (4'h8, 4'h8) gives p=8'h40.
  - 7×−8 gives p=8'hC8.
  - Repeating −8×−8 in unsigned mode gives p=8'h40 (8×8 = 64).
- Handshake integrity, WIDTH=4:
  - Start 3×5, then while busy pulse start with a=15, b=15 and also change a and b.
  - Result is p=15, exactly one done, and no second operation starts.
- Reset mid-run:
  - Assert rst_n=0 two cycles after start.
  - busy, done and p go to 0 immediately, and no done follows.
  - After release, 2×6 gives p=12 with normal latency.
- WIDTH=8, unsigned and signed:
  - 255×255 gives p=16'hFE01 after 9 cycles.
  - Signed −128×−128 gives p=16'h4000.
  - Signed −1×127 gives p=16'hFF81.

Source files
------------

// File: rtl/seq_multi_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : seq_multi_param                                              |
// | Brief    : shift-add multiplier, signed/unsigned, start/busy/done       |
// | Revision : 1.0                                                          |
// ---------------------------------------------------------------------------
module seq_multi_param #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_neg;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;

  // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  assign w_a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == c_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
      r_p      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_CNT_W'(1);
        end
        S_DONE: begin
          r_p    <= r_neg ? -r_acc : r_acc;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign p    = r_p;

endmodule
`default_nettype wire
